sn74169_ctrl: RTL and testbench

- Upstream sequencer for the sn74169 4-bit up/down counter. It drives the counter's A, LOADB, ENPB, ENTB and U_DB inputs, and reads the counter's Q back on Q_FB.
- Turns the counter into a programmable one-shot or periodic interval timer: load a preset, step at a prescaled rate to a terminal value, pulse DONE, then optionally reload.
- All outputs are registered, so the counter acts on them at the next CLK edge.

---
 rtl/sn74169_ctrl.sv | 131 +++++++++++++
 tb/tb_sn74169_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sn74169_ctrl.sv
// Sequencer for an sn74169 4-bit up/down counter: loads a preset, steps it at a
// prescaled rate to a terminal value, pulses DONE, and optionally reloads.
module sn74169_ctrl #(
  parameter int DIV = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       MODE,
  input  logic       DIR,
  input  logic [3:0] PRESET,
  input  logic [3:0] TERMV,
  input  logic [3:0] Q_FB,
  output logic [3:0] A,
  output logic       LOADB,
  output logic       ENPB,
  output logic       ENTB,
  output logic       U_DB,
  output logic       DONE,
  output logic       BUSY
);

  localparam int PC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_TERM} state_t;

  state_t          state;
  logic [3:0]      pre_l;
  logic [3:0]      term_l;
  logic            dir_l;
  logic [PC_W-1:0] pc;
  logic            step_en;
  logic [PC_W-1:0] pc_inc;
  logic            strobe_n;

  // Counter value one step short of the terminal value, modulo 16.
  function automatic logic [3:0] penult(input logic [3:0] term, input logic up);
    return up ? term - 4'd1 : term + 4'd1;
  endfunction

  // ENPB/ENTB are registered, so the strobe is computed for the following cycle.
  always_comb begin
    step_en  = (state == S_RUN) && (pc == PC_LAST);
    pc_inc   = step_en ? '0 : pc + PC_W'(1);
    strobe_n = (pc_inc != PC_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      A      <= 4'd0;
      LOADB  <= 1'b1;
      ENPB   <= 1'b1;
      ENTB   <= 1'b1;
      U_DB   <= 1'b0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
      pc     <= '0;
      pre_l  <= 4'd0;
      term_l <= 4'd0;
      dir_l  <= 1'b0;
    end else if (STOP) begin
      state <= S_IDLE;
      A     <= 4'd0;
      LOADB <= 1'b1;
      ENPB  <= 1'b1;
      ENTB  <= 1'b1;
      U_DB  <= 1'b0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
      pc    <= '0;
    end else begin
      LOADB <= 1'b1;
      ENPB  <= 1'b1;
      ENTB  <= 1'b1;
      DONE  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            pre_l  <= PRESET;
            term_l <= TERMV;
            dir_l  <= DIR;
            state  <= S_LOAD;
            LOADB  <= 1'b0;
            A      <= PRESET;
            U_DB   <= DIR;
            BUSY   <= 1'b1;
          end
        end
        S_LOAD: begin
          pc <= '0;
          if (pre_l == term_l) begin
            state <= S_TERM;
            DONE  <= 1'b1;
          end else begin
            state <= S_RUN;
            ENPB  <= (PC_LAST != '0);
            ENTB  <= (PC_LAST != '0);
          end
        end
        S_RUN: begin
          // The counter reaches TERMV at the same edge that moves us to TERM.
          if (step_en && (Q_FB == penult(term_l, dir_l))) begin
            state <= S_TERM;
            DONE  <= 1'b1;
          end else begin
            pc   <= pc_inc;
            ENPB <= strobe_n;
            ENTB <= strobe_n;
          end
        end
        S_TERM: begin
          if (MODE) begin
            state <= S_LOAD;
            LOADB <= 1'b0;
            A     <= pre_l;
          end else begin
            state <= S_IDLE;
            A     <= 4'd0;
            U_DB  <= 1'b0;
            BUSY  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sn74169_ctrl.sv
// Bench for sn74169_ctrl: two instances (DIV=1 and DIV=3) share stimulus and each
// drives its own behavioural sn74169 counter; a monitor scores DONE/LOAD events.
module tb_sn74169_ctrl;

  localparam int DIV0 = 1;
  localparam int DIV1 = 3;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode, dir;
  logic [3:0] preset, termv;
  logic [3:0] a [2];
  logic [3:0] q [2] = '{4'd0, 4'd0};
  logic       loadb [2];
  logic       enpb [2];
  logic       entb [2];
  logic       udb [2];
  logic       done [2];
  logic       busy [2];

  always #5 clk = ~clk;

  sn74169_ctrl #(.DIV(DIV0)) u_div1 (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .MODE(mode), .DIR(dir),
    .PRESET(preset), .TERMV(termv), .Q_FB(q[0]), .A(a[0]), .LOADB(loadb[0]),
    .ENPB(enpb[0]), .ENTB(entb[0]), .U_DB(udb[0]), .DONE(done[0]), .BUSY(busy[0])
  );

  sn74169_ctrl #(.DIV(DIV1)) u_div3 (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .MODE(mode), .DIR(dir),
    .PRESET(preset), .TERMV(termv), .Q_FB(q[1]), .A(a[1]), .LOADB(loadb[1]),
    .ENPB(enpb[1]), .ENTB(entb[1]), .U_DB(udb[1]), .DONE(done[1]), .BUSY(busy[1])
  );

  // Behavioural sn74169: synchronous load beats count; count needs both enables low.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (loadb[i] == 1'b0) q[i] <= a[i];
      else if (enpb[i] == 1'b0 && entb[i] == 1'b0) q[i] <= udb[i] ? q[i] + 4'd1 : q[i] - 4'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  // Current sequence as seen by the reference model.
  int         t_start = -100;
  int         t_end [2] = '{-100, -100};
  int         per [2] = '{2, 2};
  int         nsteps = 0;
  logic [3:0] cur_pre = 4'd0;
  logic [3:0] cur_tv = 4'd0;
  logic       cur_dir = 1'b0;
  int         dq [2][$];
  int         lq [2][$];
  bit         mon_en = 1'b0;

  bit act;
  bit exp_en;
  int u_pos;
  int front;

  // Monitor: per-cycle enable/busy checks plus scoreboard pops on DONE and LOADB.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        act = (cyc > t_start) && (cyc <= t_end[i]);
        chk("entb_eq_enpb", int'(entb[i]), int'(enpb[i]));
        chk("busy", int'(busy[i]), int'(act));
        if (act) chk("u_db", int'(udb[i]), int'(cur_dir));
        exp_en = 1'b0;
        if (act) begin
          u_pos  = (cyc - t_start - 1) % per[i];
          exp_en = (u_pos >= 1) && (u_pos <= nsteps * div_of(i)) && (u_pos % div_of(i) == 0);
        end
        chk("enpb_strobe", int'(enpb[i]), int'(!exp_en));

        while (dq[i].size() > 0 && dq[i][0] < cyc) begin
          chk("done_missing_cycle", cyc, dq[i][0]);
          void'(dq[i].pop_front());
        end
        if (done[i]) begin
          if (dq[i].size() == 0) chk("done_unexpected", 1, 0);
          else begin
            front = dq[i].pop_front();
            chk("done_cycle", cyc, front);
          end
          chk("done_q", int'(q[i]), int'(cur_tv));
        end

        while (lq[i].size() > 0 && lq[i][0] < cyc) begin
          chk("load_missing_cycle", cyc, lq[i][0]);
          void'(lq[i].pop_front());
        end
        if (loadb[i] == 1'b0) begin
          if (lq[i].size() == 0) chk("load_unexpected", 1, 0);
          else begin
            front = lq[i].pop_front();
            chk("load_cycle", cyc, front);
          end
          chk("load_a", int'(a[i]), int'(cur_pre));
        end
      end
    end
  end

  // kind: 0 none, 1 STOP, 2 STOP+START, 3 RST; negative kind/off picks randomly.
  task automatic trial(input bit m, input bit d, input logic [3:0] p, input logic [3:0] tv,
                       input int kind_in, input int off_in);
    int c, s, n, pmin, pmax, kind, off, u, ld, dn, steps;
    logic [3:0] frz [2];
    c = cyc;
    n = d ? ((int'(tv) - int'(p)) & 15) : ((int'(p) - int'(tv)) & 15);
    for (int i = 0; i < 2; i++) per[i] = n * div_of(i) + 2;
    pmin = per[0];
    pmax = per[1];
    kind = kind_in;
    off  = off_in;
    if (kind < 0) kind = m ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
    if (off < 0) off = m ? int'($urandom_range(1, 2 * pmax + 3)) : int'($urandom_range(1, pmin - 1));
    s = (kind == 0) ? c + pmax : c + off;
    for (int i = 0; i < 2; i++) begin
      t_end[i] = (kind == 0) ? c + per[i] : s;
      for (int k = 0; k < 1000; k++) begin
        ld = c + 1 + k * per[i];
        if (ld > t_end[i]) break;
        lq[i].push_back(ld);
        dn = c + (k + 1) * per[i];
        if (dn <= t_end[i]) dq[i].push_back(dn);
        if (!m) break;
      end
      u = (s - c) % per[i];
      steps = (u == 0) ? n : (u - 1) / div_of(i);
      frz[i] = d ? p + 4'(steps) : p - 4'(steps);
    end
    t_start = c;
    nsteps  = n;
    cur_pre = p;
    cur_tv  = tv;
    cur_dir = d;
    mode = m; dir = d; preset = p; termv = tv; start = 1'b1;
    while (cyc < s) begin
      @(negedge clk);
      preset = 4'($urandom);
      termv  = 4'($urandom);
      dir    = 1'($urandom);
      start  = 1'b0;
      if (cyc < s && (m || cyc <= c + pmin)) start = 1'($urandom);
      if (cyc == s) begin
        start = 1'b0;
        if (kind == 1) stop = 1'b1;
        if (kind == 2) begin stop = 1'b1; start = 1'b1; end
        if (kind == 3) rst = 1'b1;
      end
    end
    @(negedge clk);
    stop = 1'b0; start = 1'b0; rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (kind == 0) chk("final_q", int'(q[i]), int'(tv));
      else begin
        chk("abort_q", int'(q[i]), int'(frz[i]));
        chk("abort_done", int'(done[i]), 0);
        chk("abort_loadb", int'(loadb[i]), 1);
        if (kind == 3) begin
          chk("rst_a", int'(a[i]), 0);
          chk("rst_udb", int'(udb[i]), 0);
        end
      end
    end
    @(negedge clk);
    if (kind != 0) for (int i = 0; i < 2; i++) chk("hold_q", int'(q[i]), int'(frz[i]));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;
    preset = 4'd0; termv = 4'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_a", int'(a[i]), 0);
      chk("reset_loadb", int'(loadb[i]), 1);
      chk("reset_enpb", int'(enpb[i]), 1);
      chk("reset_entb", int'(entb[i]), 1);
      chk("reset_udb", int'(udb[i]), 0);
      chk("reset_done", int'(done[i]), 0);
      chk("reset_busy", int'(busy[i]), 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    trial(1'b0, 1'b0, 4'd5,  4'd0,  0, 0);
    trial(1'b0, 1'b1, 4'd13, 4'd2,  0, 0);
    trial(1'b1, 1'b0, 4'd3,  4'd0,  1, 23);
    trial(1'b1, 1'b0, 4'd7,  4'd7,  1, 6);
    trial(1'b0, 1'b0, 4'd9,  4'd1,  2, 4);
    trial(1'b0, 1'b1, 4'd2,  4'd12, 3, 5);
    trial(1'b0, 1'b0, 4'd7,  4'd7,  0, 0);
    for (int t = 0; t < 40; t++)
      trial(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), -1, -1);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("done_queue_left", dq[i].size(), 0);
      chk("load_queue_left", lq[i].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
